// File: rtl/ans_table_loader.sv
// ans_table_loader: loads the ANS decoder's per-symbol count table from a
// 4-bit nibble stream, then builds the cumulative (prefix-sum) table one
// entry per cycle and holds both stable while tbl_vld is high.
// Optional feature macro: ANS_TABLE_CHECK_EN adds an ERR state that rejects
// an all-zero table (tbl_err=1). Without it tbl_err is tied low.
// Handshake: a nibble transfers on a clk edge where in_vld && in_rdy && ena;
// in_rdy is a registered output that is high only while loading, and the
// producer must hold `in` stable while in_vld is high and not yet accepted.
module ans_table_loader #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 8,
    parameter int SYM_COUNT = 2 ** SYM_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     ena,
    input  logic [3:0]                               in,
    input  logic                                     in_vld,
    output logic                                     in_rdy,
    input  logic                                     reload,
    output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
    output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
    output logic                                     tbl_vld,
    output logic                                     tbl_err
);

    localparam int NIBS  = CNT_WIDTH / 4;
    localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int CUM_W = CNT_WIDTH + SYM_WIDTH;

    localparam logic [SYM_WIDTH-1:0] LAST_SYM = SYM_WIDTH'(SYM_COUNT - 1);
    localparam logic [NIB_W-1:0]     LAST_NIB = NIB_W'(NIBS - 1);

`ifdef ANS_TABLE_CHECK_EN
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ACCUM = 2'd1,
        S_READY = 2'd2,
        S_ERR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ACCUM = 2'd1,
        S_READY = 2'd2
    } state_t;
`endif

    state_t                             state_q, state_d;
    logic [SYM_WIDTH-1:0]               sym_ptr_q, sym_ptr_d;
    logic [NIB_W-1:0]                   nib_ptr_q, nib_ptr_d;
    logic [CNT_WIDTH*SYM_COUNT-1:0]     counts_q, counts_d;
    logic [CUM_W*SYM_COUNT-1:0]         cum_q, cum_d;
    logic                               in_rdy_q, in_rdy_d;
    logic                               tbl_vld_q, tbl_vld_d;
`ifdef ANS_TABLE_CHECK_EN
    logic                               tbl_err_q, tbl_err_d;
`endif

    // sym_ptr doubles as the accumulation index once loading is done
    logic [SYM_WIDTH-1:0] prev_idx;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic [CUM_W-1:0]     prev_cum;
    logic [CUM_W-1:0]     cum_new;

    // Prefix-sum datapath for the entry at sym_ptr (entry 0 has no predecessor)
    always_comb begin
        prev_idx = sym_ptr_q - SYM_WIDTH'(1);
        cur_cnt  = counts_q[int'(sym_ptr_q)*CNT_WIDTH +: CNT_WIDTH];
        prev_cum = (sym_ptr_q == '0) ? '0 : cum_q[int'(prev_idx)*CUM_W +: CUM_W];
        cum_new  = prev_cum + CUM_W'(cur_cnt);
    end

    // Next-state logic: reload dominates, otherwise LOAD -> ACCUM -> READY (or ERR)
    always_comb begin
        state_d   = state_q;
        sym_ptr_d = sym_ptr_q;
        nib_ptr_d = nib_ptr_q;
        counts_d  = counts_q;
        cum_d     = cum_q;
        in_rdy_d  = in_rdy_q;
        tbl_vld_d = tbl_vld_q;
`ifdef ANS_TABLE_CHECK_EN
        tbl_err_d = tbl_err_q;
`endif
        if (ena) begin
            if (reload) begin
                state_d   = S_LOAD;
                sym_ptr_d = '0;
                nib_ptr_d = '0;
                counts_d  = '0;
                cum_d     = '0;
                in_rdy_d  = 1'b1;
                tbl_vld_d = 1'b0;
`ifdef ANS_TABLE_CHECK_EN
                tbl_err_d = 1'b0;
`endif
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (in_vld && in_rdy_q) begin
                            counts_d[int'(sym_ptr_q)*CNT_WIDTH + int'(nib_ptr_q)*4 +: 4] = in;
                            if (nib_ptr_q == LAST_NIB) begin
                                nib_ptr_d = '0;
                                sym_ptr_d = sym_ptr_q + SYM_WIDTH'(1);
                                if (sym_ptr_q == LAST_SYM) begin
                                    state_d  = S_ACCUM;
                                    in_rdy_d = 1'b0;
                                end
                            end else begin
                                nib_ptr_d = nib_ptr_q + NIB_W'(1);
                            end
                        end
                    end
                    S_ACCUM: begin
                        cum_d[int'(sym_ptr_q)*CUM_W +: CUM_W] = cum_new;
                        sym_ptr_d = sym_ptr_q + SYM_WIDTH'(1);
                        if (sym_ptr_q == LAST_SYM) begin
`ifdef ANS_TABLE_CHECK_EN
                            if (cum_new == '0) begin
                                state_d   = S_ERR;
                                tbl_err_d = 1'b1;
                            end else begin
                                state_d   = S_READY;
                                tbl_vld_d = 1'b1;
                            end
`else
                            state_d   = S_READY;
                            tbl_vld_d = 1'b1;
`endif
                        end
                    end
                    default: ;  // READY / ERR hold everything until reload
                endcase
            end
        end
    end

    // All state and registered outputs; reset returns to an empty LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            sym_ptr_q <= '0;
            nib_ptr_q <= '0;
            counts_q  <= '0;
            cum_q     <= '0;
            in_rdy_q  <= 1'b1;
            tbl_vld_q <= 1'b0;
`ifdef ANS_TABLE_CHECK_EN
            tbl_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sym_ptr_q <= sym_ptr_d;
            nib_ptr_q <= nib_ptr_d;
            counts_q  <= counts_d;
            cum_q     <= cum_d;
            in_rdy_q  <= in_rdy_d;
            tbl_vld_q <= tbl_vld_d;
`ifdef ANS_TABLE_CHECK_EN
            tbl_err_q <= tbl_err_d;
`endif
        end
    end

    assign in_rdy              = in_rdy_q;
    assign tbl_vld             = tbl_vld_q;
    assign counts_unpacked     = counts_q;
    assign cumulative_unpacked = cum_q;
`ifdef ANS_TABLE_CHECK_EN
    assign tbl_err = tbl_err_q;
`else
    assign tbl_err = 1'b0;
`endif

endmodule

// File: tb/tb_ans_table_loader.sv
// Directed testbench for ans_table_loader (default parameters: 16 symbols,
// 8-bit counts, 12-bit cumulative entries).
module tb_ans_table_loader;

    localparam int SYM_COUNT = 16;
    localparam int CNT_W     = 8;
    localparam int CUM_W     = 12;

    logic                          clk;
    logic                          rst_n;
    logic                          ena;
    logic [3:0]                    in_nib;
    logic                          in_vld;
    logic                          in_rdy;
    logic                          reload;
    logic [CNT_W*SYM_COUNT-1:0]    counts_unpacked;
    logic [CUM_W*SYM_COUNT-1:0]    cumulative_unpacked;
    logic                          tbl_vld;
    logic                          tbl_err;

    int n_cmp;
    int n_err;
    int cnt_tbl[SYM_COUNT];
    logic [31:0] exp_q[$];

    ans_table_loader dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ena                 (ena),
        .in                  (in_nib),
        .in_vld              (in_vld),
        .in_rdy              (in_rdy),
        .reload              (reload),
        .counts_unpacked     (counts_unpacked),
        .cumulative_unpacked (cumulative_unpacked),
        .tbl_vld             (tbl_vld),
        .tbl_err             (tbl_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [3:0] nibble_of(input int j);
        int v;
        v = cnt_tbl[j / 2];
        return 4'((v >> (4 * (j % 2))) & 15);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send the first n nibbles of cnt_tbl. rnd inserts idle gaps; stall_at
    // freezes the block with ena=0 for 5 cycles while a bogus nibble is valid.
    task automatic send_nibbles(input int n, input bit rnd, input int stall_at);
        for (int j = 0; j < n; j++) begin
            if (j == stall_at) begin
                ena    = 1'b0;
                in_vld = 1'b1;
                in_nib = 4'hF;
                repeat (5) tick();
                check("stall_in_rdy", 32'(in_rdy), 1);
                ena = 1'b1;
            end
            if (rnd) begin
                int gaps;
                gaps   = $urandom_range(0, 2);
                in_vld = 1'b0;
                in_nib = 4'hA;
                repeat (gaps) tick();
            end
            in_nib = nibble_of(j);
            in_vld = 1'b1;
            if (!in_rdy) begin
                check("in_rdy_during_load", 32'(in_rdy), 1);
                in_vld = 1'b0;
                return;
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic pulse_reload(input bit with_nibble);
        reload = 1'b1;
        in_vld = with_nibble;
        in_nib = 4'hF;
        tick();
        reload = 1'b0;
        in_vld = 1'b0;
    endtask

    // Cycles from now until tbl_vld rises (bounded)
    task automatic wait_vld(output int k);
        k = 0;
        while (!tbl_vld && k < 40) begin
            tick();
            k++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_tables(input string tag);
        int sum;
        sum = 0;
        for (int i = 0; i < SYM_COUNT; i++) begin
            sum += cnt_tbl[i];
            exp_q.push_back(32'(sum));
        end
        for (int i = 0; i < SYM_COUNT; i++) begin
            logic [31:0] e;
            check({tag, "_cnt"}, 32'(counts_unpacked[i*CNT_W +: CNT_W]), 32'(cnt_tbl[i]));
            e = exp_q.pop_front();
            check({tag, "_cum"}, 32'(cumulative_unpacked[i*CUM_W +: CUM_W]), e);
        end
    endtask

    function automatic logic [31:0] cum_at(input int i);
        return 32'(cumulative_unpacked[i*CUM_W +: CUM_W]);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int k;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        in_nib = 4'h0;
        in_vld = 1'b0;
        reload = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_in_rdy", 32'(in_rdy), 1);
        check("rst_tbl_vld", 32'(tbl_vld), 0);
        check("rst_tbl_err", 32'(tbl_err), 0);
        check("rst_counts", 32'(|counts_unpacked), 0);
        check("rst_cum", 32'(|cumulative_unpacked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: all counts 1, in_vld held high
        for (int i = 0; i < SYM_COUNT; i++) cnt_tbl[i] = 1;
        send_nibbles(31, 1'b0, -1);
        check("t1_rdy_before_last", 32'(in_rdy), 1);
        in_nib = nibble_of(31);
        in_vld = 1'b1;
        tick();
        check("t1_rdy_fell", 32'(in_rdy), 0);
        wait_vld(k);
        in_vld = 1'b0;
        check("t1_latency", 32'(k), 16);
        check("t1_cum15", cum_at(15), 16);
        check_tables("t1");
        // inputs ignored in READY
        in_vld = 1'b1;
        in_nib = 4'hF;
        repeat (3) tick();
        in_vld = 1'b0;
        check("t1_ready_hold_vld", 32'(tbl_vld), 1);
        check("t1_ready_rdy", 32'(in_rdy), 0);
        check_tables("t1_hold");

        // 2: count[i] = i*16+15, random in_vld gaps
        pulse_reload(1'b0);
        check("t2_reload_rdy", 32'(in_rdy), 1);
        check("t2_reload_vld", 32'(tbl_vld), 0);
        check("t2_reload_cum", 32'(|cumulative_unpacked), 0);
        for (int i = 0; i < SYM_COUNT; i++) cnt_tbl[i] = i * 16 + 15;
        send_nibbles(32, 1'b1, -1);
        wait_vld(k);
        check("t2_latency", 32'(k), 16);
        check("t2_cnt15", 32'(counts_unpacked[15*CNT_W +: CNT_W]), 255);
        check("t2_cum15", cum_at(15), 2160);  // 15+31+...+255
        check_tables("t2");

        // 3: reload after 10 nibbles, then reload with a colliding nibble
        pulse_reload(1'b0);
        send_nibbles(10, 1'b0, -1);
        pulse_reload(1'b0);
        check("t3_rdy", 32'(in_rdy), 1);
        check("t3_counts_clr", 32'(|counts_unpacked), 0);
        pulse_reload(1'b1);
        check("t3_drop_counts", 32'(|counts_unpacked), 0);
        for (int i = 0; i < SYM_COUNT; i++) cnt_tbl[i] = 2;
        send_nibbles(32, 1'b0, -1);
        wait_vld(k);
        check("t3_latency", 32'(k), 16);
        check("t3_cum15", cum_at(15), 32);
        check_tables("t3");

        // 5: ena low 5 cycles mid-load with in_vld high
        pulse_reload(1'b0);
        for (int i = 0; i < SYM_COUNT; i++) cnt_tbl[i] = i * 7 + 3;
        send_nibbles(32, 1'b0, 9);
        wait_vld(k);
        check("t5_latency", 32'(k), 16);
        check("t5_cum15", cum_at(15), 888);
        check_tables("t5");

        // 4: async reset during ACCUM at idx 7
        pulse_reload(1'b0);
        for (int i = 0; i < SYM_COUNT; i++) cnt_tbl[i] = 1;
        send_nibbles(32, 1'b0, -1);
        repeat (7) tick();
        check("t4_cum6_before", cum_at(6), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_vld", 32'(tbl_vld), 0);
        check("t4_rdy", 32'(in_rdy), 1);
        check("t4_cum", 32'(|cumulative_unpacked), 0);
        check("t4_counts", 32'(|counts_unpacked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 6: all counts zero
        for (int i = 0; i < SYM_COUNT; i++) cnt_tbl[i] = 0;
        send_nibbles(32, 1'b0, -1);
        repeat (20) tick();
`ifdef ANS_TABLE_CHECK_EN
        check("t6_err", 32'(tbl_err), 1);
        check("t6_vld", 32'(tbl_vld), 0);
        pulse_reload(1'b0);
        check("t6_err_clr", 32'(tbl_err), 0);
        check("t6_rdy", 32'(in_rdy), 1);
`else
        check("t6_err", 32'(tbl_err), 0);
        check("t6_vld", 32'(tbl_vld), 1);
        check_tables("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
